// File: rtl/mac_requantizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mac_requantizer
//  Description : Requantization stage behind the MAC grid. Adds a per-layer
//                bias to each 32-bit accumulator sum, applies a rounding
//                arithmetic right shift and an optional ReLU, then saturates
//                to OUT_WIDTH bits. Results are written one after another
//                into the next layer's activation memory. The datapath is a
//                three-stage pipeline; the layer runs under a start/done
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_requantizer #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int NUM_OUTPUTS = 256,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ACC_WIDTH-1:0]   cfg_bias,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_relu,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_WIDTH-1:0]   in_acc,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [OUT_WIDTH-1:0]   wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sat_count
);

  // Bias sum needs one extra bit, the rounding add one more, so neither wraps.
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam int RND_W = ACC_WIDTH + 2;
  localparam int CNT_W = $clog2(NUM_OUTPUTS + 1);

  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NUM_OUTPUTS - 1);

  // Output range limits, sign-extended to the rounding width.
  localparam logic signed [RND_W-1:0] C_OUT_MAX =
    {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] C_OUT_MIN =
    {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  localparam logic [15:0] C_SAT_MAX = 16'hFFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]             state_q;
  logic [1:0]             state_d;

  logic [ACC_WIDTH-1:0]   bias_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   relu_q;

  logic [CNT_W-1:0]       acc_cnt_q;
  logic [ADDR_WIDTH-1:0]  wr_cnt_q;

  logic                   s1_valid_q;
  logic [SUM_W-1:0]       s1_sum_q;
  logic                   s2_valid_q;
  logic signed [RND_W-1:0] s2_r_q;

  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [OUT_WIDTH-1:0]   wr_data_q;
  logic [15:0]            sat_cnt_q;

  logic                   start_acc;
  logic                   accept;
  logic                   last_accept;
  logic                   pipe_empty;

  logic [SUM_W-1:0]       sum_w;
  logic [RND_W-1:0]       round_w;
  logic signed [RND_W-1:0] biased_w;
  logic signed [RND_W-1:0] shifted_w;
  logic [OUT_WIDTH-1:0]   result_w;
  logic                   clamped_w;

  // A start is only honoured from IDLE; elsewhere it is ignored.
  assign start_acc   = start && (state_q == ST_IDLE);
  assign accept      = in_valid && (state_q == ST_RUN);
  assign last_accept = accept && (acc_cnt_q == C_LAST_IDX);
  assign pipe_empty  = !s1_valid_q && !s2_valid_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: DRAIN ends once the last result sits in the write stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)       state_d = ST_RUN;
      ST_RUN:   if (last_accept) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty)  state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy stays high through DONE and falls together with done.
  always_comb begin
    in_ready = (state_q == ST_RUN);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
  end

  // Layer configuration, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (start_acc) begin
      bias_q  <= cfg_bias;
      shift_q <= cfg_shift;
      relu_q  <= cfg_relu;
    end
  end

  // Accept counter: determines when the run has taken NUM_OUTPUTS inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q <= '0;
    end else if (start_acc) begin
      acc_cnt_q <= '0;
    end else if (accept) begin
      acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  // Stage 1 sum, sign-extended by one bit so it cannot overflow.
  assign sum_w = {in_acc[ACC_WIDTH-1], in_acc} + {bias_q[ACC_WIDTH-1], bias_q};

  // Stage 1 register: bias add on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q <= sum_w;
      end
    end
  end

  // Rounding constant 2^(shift-1); a zero shift passes the sum through untouched.
  always_comb begin
    round_w = '0;
    if (shift_q != '0) begin
      round_w = RND_W'(1) << (shift_q - SHIFT_WIDTH'(1));
    end
  end

  // Round half toward +inf, then arithmetic shift.
  assign biased_w  = $signed({s1_sum_q[SUM_W-1], s1_sum_q}) + $signed(round_w);
  assign shifted_w = biased_w >>> shift_q;

  // Stage 2 register: rounded and shifted value.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_r_q <= shifted_w;
      end
    end
  end

  // ReLU takes priority and never counts as saturation; the clamp does.
  always_comb begin
    result_w  = s2_r_q[OUT_WIDTH-1:0];
    clamped_w = 1'b0;
    if (relu_q && s2_r_q[RND_W-1]) begin
      result_w = '0;
    end else if (s2_r_q > C_OUT_MAX) begin
      result_w  = C_OUT_MAX[OUT_WIDTH-1:0];
      clamped_w = 1'b1;
    end else if (s2_r_q < C_OUT_MIN) begin
      result_w  = C_OUT_MIN[OUT_WIDTH-1:0];
      clamped_w = 1'b1;
    end
  end

  // Stage 3 register: memory write port; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      wr_en_q <= s2_valid_q;
      if (start_acc) begin
        wr_cnt_q <= '0;
      end else if (s2_valid_q) begin
        wr_addr_q <= wr_cnt_q;
        wr_data_q <= result_w;
        wr_cnt_q  <= wr_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Saturation counter: cleared per run, sticky at all-ones, held after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else if (start_acc) begin
      sat_cnt_q <= '0;
    end else if (s2_valid_q && clamped_w && (sat_cnt_q != C_SAT_MAX)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign sat_count = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_requantizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mac_requantizer
//  Description : Scoreboard bench for mac_requantizer. Stimulus pushes the
//                expected write of every accepted input; a monitor pops and
//                compares on each wr_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_requantizer;

  localparam int NUM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cfg_bias;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_acc;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] sat_count;

  mac_requantizer #(
    .ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT_WIDTH(5), .NUM_OUTPUTS(NUM), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .in_valid(in_valid),
    .in_ready(in_ready), .in_acc(in_acc), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  addr;
    logic [15:0] sat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] acc_list[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mdl_sat;
  int          mdl_addr;
  int          last_wr_cyc = -100;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the layer rules.
  function automatic logic [15:0] ref_q(input logic [31:0] acc, input logic [31:0] bias,
                                        input int sh, input bit relu, output bit sat);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(bias));
    if (sh > 0) s = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    sat = 1'b0;
    if (relu && s < 0) return 16'h0000;
    if (s > 32767) begin sat = 1'b1; return 16'h7FFF; end
    if (s < -32768) begin sat = 1'b1; return 16'h8000; end
    return s[15:0];
  endfunction

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wr_en=1 addr=%0h data=%0h, expected no write (cycle %0d)",
                 wr_addr, wr_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_data", wr_data, mon_e.data);
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("sat_count", sat_count, mon_e.sat);
        chk("wr_latency", cyc, mon_e.cyc);
      end
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) begin
      chk("done_after_last_write", cyc, last_wr_cyc + 1);
      chk("busy_with_done", busy, 1);
      done_cnt++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sat_count"}, sat_count, 0);
  endtask

  // One layer run over acc_list; vpct is the in_valid probability in percent.
  task automatic run_layer(input logic [31:0] bias, input int sh, input bit relu,
                           input int vpct, input bit noisy);
    int   idx;
    int   guard;
    int   d0;
    bit   sat;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; cfg_bias = bias; cfg_shift = 5'(sh); cfg_relu = relu;
    mdl_sat = 16'h0000;
    mdl_addr = 0;
    @(posedge clk); #1;
    start = 1'b0; cfg_bias = $urandom; cfg_shift = 5'($urandom); cfg_relu = 1'($urandom);
    chk("busy_after_start", busy, 1);
    idx = 0;
    guard = 0;
    while (idx < NUM && guard < 200) begin
      in_valid = ($urandom_range(99) < vpct);
      in_acc   = in_valid ? acc_list[idx] : $urandom;
      start    = noisy && ($urandom_range(3) == 0);
      if (in_valid && in_ready) begin
        e.data = ref_q(acc_list[idx], bias, sh, relu, sat);
        if (sat && mdl_sat != 16'hFFFF) mdl_sat++;
        e.sat  = mdl_sat;
        e.addr = 8'(mdl_addr);
        e.cyc  = cyc + 3;
        sb.push_back(e);
        mdl_addr++;
        idx++;
      end
      guard++;
      @(posedge clk); #1;
    end
    if (idx < NUM) begin
      checks++;
      errors++;
      $display("FAIL run_accepts: got %0d accepts, expected %0d within bound", idx, NUM);
    end
    in_valid = 1'b0;
    chk("in_ready_after_last", in_ready, 0);
    chk("busy_in_drain", busy, 1);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("done_seen", (done_cnt != d0), 1);
    chk("busy_after_done", busy, 0);
    chk("done_low_after", done, 0);
    chk("in_ready_idle", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", done_cnt - d0, 1);
    chk("scoreboard_drained", sb.size(), 0);
    chk("sat_count_hold", sat_count, mdl_sat);
    chk("wr_addr_hold", wr_addr, NUM - 1);
    sb.delete();
  endtask

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(3))
      0:       return $urandom;
      1:       return 32'($urandom_range(4000)) - 32'd2000;
      2:       return ($urandom_range(1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'($urandom_range(200000)) - 32'd100000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_bias = '0; cfg_shift = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; in_acc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Plain pass-through with in_valid held high: consecutive addresses.
    acc_list = '{32'd100, -32'sd5, 32'd32767, -32'sd32768};
    run_layer(32'd0, 0, 1'b0, 100, 1'b1);

    // Rounding of exact halves at shift 4.
    acc_list = '{32'd520, -32'sd520, 32'd8, -32'sd8};
    run_layer(32'd0, 4, 1'b0, 100, 1'b0);

    // ReLU zeroing versus positive saturation.
    acc_list = '{-32'sd5, 32'd5, -32'sd100000, 32'd100000};
    run_layer(32'd0, 0, 1'b1, 100, 1'b0);

    // Extremes with bias +1 and -1: no wrap, both clamp directions.
    acc_list = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, -32'sd2};
    run_layer(32'd1, 0, 1'b0, 100, 1'b0);
    acc_list = '{32'd0, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF};
    run_layer(32'hFFFF_FFFF, 0, 1'b0, 70, 1'b1);

    // Reset with two values in flight: nothing may be written.
    @(posedge clk); #1;
    start = 1'b1; cfg_bias = 32'd7; cfg_shift = 5'd0; cfg_relu = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_acc = 32'd1000 + 32'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrun_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Fresh run after reset must start at address 0.
    acc_list = '{32'd300, 32'd301, 32'd302, 32'd303};
    run_layer(32'd0, 1, 1'b0, 100, 1'b0);

    // Maximum shift.
    acc_list = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'hC000_0000};
    run_layer(32'h4000_0000, 31, 1'b0, 100, 1'b0);

    // Randomised layers.
    for (int l = 0; l < 30; l++) begin
      logic [31:0] b;
      acc_list.delete();
      for (int k = 0; k < NUM; k++) acc_list.push_back(rand_acc());
      b = ($urandom_range(1) == 0) ? $urandom : (32'($urandom_range(2000)) - 32'd1000);
      run_layer(b, $urandom_range(31), 1'($urandom), $urandom_range(40, 100), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
